sw_input_conditioner: RTL and testbench
=======================================

// Module: sw_input_conditioner
// PURPOSE
//  Front-end for the raw board switches that drive the CPU's 9-bit SW input.
//  SW8 is the branch-condition switch and SW7-0 are the data switches.
//  - Synchronises each asynchronous switch to clk through two flops.
//  - Debounces each bit with its own counter.
//  - Delivers a glitch-free sw_clean vector for direct connection to cpu.SW.
//  - Provides one-cycle rise/fall pulses for per-event logic.
// PARAMETERS
//  N_SW            9   number of switch bits conditioned
//  DEBOUNCE_CYCLES 16  consecutive cycles a new level must persist (>=2)
//  RESET_VALUE     0   N_SW-bit value loaded into sync flops and sw_clean on reset
// PORTS
//  clk        in   1     system clock, rising-edge
//  reset      in   1     synchronous, active-high reset
//  sw_raw     in   N_SW  asynchronous switch levels from pins
//  sw_clean   out  N_SW  debounced switch levels, registered; feeds cpu.SW
//  sw_rise    out  N_SW  1-cycle pulse per bit on sw_clean 0->1
//  sw_fall    out  N_SW  1-cycle pulse per bit on sw_clean 1->0
//  stable     out  1     1 when no bit has a debounce in progress
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1):
//    - s1, s2, sw_clean and clean_d are all set to RESET_VALUE.
//    - All counters are cleared.
//    - Result: sw_rise=sw_fall=0 and stable=1 in the following cycle.
//    - Any in-progress debounce is discarded; no pulse is generated by reset.
//  - Synchroniser: s1<=sw_raw; s2<=s1 on every edge.
//  - Per-bit counter cnt[i], width $clog2(DEBOUNCE_CYCLES), evaluated each edge:
//    - s2[i]==sw_clean[i]: cnt[i]<=0.
//    - s2[i]!=sw_clean[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
//    - s2[i]!=sw_clean[i] and cnt[i]==DEBOUNCE_CYCLES-1: sw_clean[i]<=s2[i] and cnt[i]<=0.
//  - Latency:
//    - sw_raw is sampled at edge E0 and then held.
//    - sw_clean updates at edge E0+DEBOUNCE_CYCLES+1.
//  - Bounce: any return of s2[i] to sw_clean[i] before the terminal count restarts that bit from 0.
//  - Bits are fully independent.
//    - Simultaneous changes on several bits update on the same edge.
//    - A bounce on one bit never affects another bit's counter.
//  - Edges: clean_d<=sw_clean every edge.
//    - sw_rise = sw_clean & ~clean_d; sw_fall = ~sw_clean & clean_d.
//    - Each pulse is high exactly one cycle, in the cycle after sw_clean changes.
//  - stable = (all cnt==0); combinational from registers.
// CONFIGURATION
//  Macro SWCOND_GLITCH_CNT_EN:
//  - Defined: adds output port glitch_cnt (8 bits), reset to 0.
//    - Increments by 1 on each edge where at least one bit's cnt goes from nonzero to 0
//      because s2 returned to sw_clean (an aborted debounce).
//    - Multiple bits aborting on the same edge count once.
//    - Saturates at 8'hFF.
//    - A completed debounce does not count.
//  - Undefined: no port, no logic; all other behaviour is identical.
// TESTING  (bench uses N_SW=9, DEBOUNCE_CYCLES=4, RESET_VALUE=0)
//  1. reset=1 for 3 cycles with sw_raw=9'h1FF, then release
//     -> sw_clean=0, sw_rise=0, stable=1 through the first cycle after reset;
//        sw_clean=9'h1FF exactly 5 edges after the first post-reset sampling edge.
//  2. From 0, sw_raw[8]=1 held
//     -> sw_clean[8] rises at edge E0+5;
//        sw_rise[8]=1 for exactly one cycle;
//        stable=0 while counting.
//  3. sw_raw[0]=1 for 2 cycles, then 0
//     -> sw_clean[0] stays 0; no sw_rise[0];
//        glitch_cnt 0->1 (with macro).
//  4. sw_raw[8] 1->0 held after test 2
//     -> sw_clean[8] falls at E0+5; sw_fall[8] is a 1-cycle pulse; sw_rise stays 0.
//  5. sw_raw[3] and sw_raw[7] set on the same edge, bit 3 dropped for 1 cycle mid-count
//     -> bit 7 updates at E0+5;
//        bit 3 restarts and updates 4 edges after its stable reappearance in s2.
//  6. sw_raw[5]=1, reset pulsed 1 cycle while cnt[5]=2
//     -> after reset: sw_clean[5]=0, stable=1 momentarily, no pulse;
//        debounce then completes from scratch.

Source files
------------

// File: rtl/sw_input_conditioner.sv
// Two-flop synchroniser plus per-bit debounce counter and edge pulses for the board switches.
// Define SWCOND_GLITCH_CNT_EN to add an 8-bit saturating count of aborted debounces (glitch_cnt).
module sw_input_conditioner #(
    parameter int              N_SW            = 9,
    parameter int              DEBOUNCE_CYCLES = 16,
    parameter logic [N_SW-1:0] RESET_VALUE     = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
`ifdef SWCOND_GLITCH_CNT_EN
    output logic [7:0]      glitch_cnt,
`endif
    output logic            stable
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0] s1;
    logic [N_SW-1:0] s2;
    logic [N_SW-1:0] clean_d;
    logic [CW-1:0]   cnt [N_SW];

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, as the flops would.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= RESET_VALUE;
            s2       <= RESET_VALUE;
            sw_clean <= RESET_VALUE;
            clean_d  <= RESET_VALUE;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= sw_raw;
            s2      <= s1;
            clean_d <= sw_clean;
            for (int i = 0; i < N_SW; i++) begin
                if (s2[i] == sw_clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    sw_clean[i] <= s2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sw_rise = sw_clean & ~clean_d;
    assign sw_fall = ~sw_clean & clean_d;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        stable = 1'b1;
        for (int i = 0; i < N_SW; i++) begin
            if (cnt[i] != '0) begin
                stable = 1'b0;
            end
        end
    end

`ifdef SWCOND_GLITCH_CNT_EN
    logic any_abort;

    // An abort is a running count collapsing because s2 fell back to the clean level.
    always_comb begin
        any_abort = 1'b0;
        for (int i = 0; i < N_SW; i++) begin
            if ((s2[i] == sw_clean[i]) && (cnt[i] != '0)) begin
                any_abort = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt <= '0;
        end else if (any_abort && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with DEBOUNCE_CYCLES=4 (clean level moves 5 edges after sampling).
// Inputs change and outputs are sampled 2 time units after each rising edge.
module tb_sw_input_conditioner;

    localparam int N_SW = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_clean;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            stable;
`ifdef SWCOND_GLITCH_CNT_EN
    logic [7:0]      glitch_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sw_input_conditioner #(
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     ('0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
`ifdef SWCOND_GLITCH_CNT_EN
        .glitch_cnt (glitch_cnt),
`endif
        .stable     (stable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        sw_raw = 9'h1FF;
        repeat (3) tick();
        n_cmp++; if (sw_clean !== 9'h000) begin n_err++; $display("FAIL reset_clean: got %h expected %h", sw_clean, 9'h000); end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL reset_stable: got %b expected 1", stable); end
        reset = 1'b0;
        tick(); // E0
        n_cmp++; if (sw_clean !== 9'h000) begin n_err++; $display("FAIL post_reset_clean: got %h expected %h", sw_clean, 9'h000); end
        n_cmp++; if (sw_rise !== 9'h000) begin n_err++; $display("FAIL post_reset_rise: got %h expected %h", sw_rise, 9'h000); end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL post_reset_stable: got %b expected 1", stable); end
        repeat (4) tick(); // E4
        n_cmp++; if (sw_clean !== 9'h000) begin n_err++; $display("FAIL t1_clean_e4: got %h expected %h", sw_clean, 9'h000); end
        n_cmp++; if (stable !== 1'b0) begin n_err++; $display("FAIL t1_stable_e4: got %b expected 0", stable); end
        tick(); // E5
        n_cmp++; if (sw_clean !== 9'h1FF) begin n_err++; $display("FAIL t1_clean_e5: got %h expected %h", sw_clean, 9'h1FF); end
        n_cmp++; if (sw_rise !== 9'h1FF) begin n_err++; $display("FAIL t1_rise_e5: got %h expected %h", sw_rise, 9'h1FF); end
        tick(); // E6
        n_cmp++; if (sw_rise !== 9'h000) begin n_err++; $display("FAIL t1_rise_e6: got %h expected %h", sw_rise, 9'h000); end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL t1_stable_e6: got %b expected 1", stable); end
    endtask

    task automatic do_reset_to_zero();
        sw_raw = 9'h000;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rise_bit8();
        do_reset_to_zero();
        n_cmp++; if (sw_clean !== 9'h000) begin n_err++; $display("FAIL t2_start_clean: got %h expected %h", sw_clean, 9'h000); end
        sw_raw = 9'h100;
        tick(); // E0
        tick(); // E1
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL t2_stable_e1: got %b expected 1", stable); end
        tick(); // E2
        n_cmp++; if (stable !== 1'b0) begin n_err++; $display("FAIL t2_stable_e2: got %b expected 0", stable); end
        repeat (2) tick(); // E4
        n_cmp++; if (sw_clean !== 9'h000) begin n_err++; $display("FAIL t2_clean_e4: got %h expected %h", sw_clean, 9'h000); end
        n_cmp++; if (stable !== 1'b0) begin n_err++; $display("FAIL t2_stable_e4: got %b expected 0", stable); end
        tick(); // E5
        n_cmp++; if (sw_clean !== 9'h100) begin n_err++; $display("FAIL t2_clean_e5: got %h expected %h", sw_clean, 9'h100); end
        n_cmp++; if (sw_rise !== 9'h100) begin n_err++; $display("FAIL t2_rise_e5: got %h expected %h", sw_rise, 9'h100); end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL t2_stable_e5: got %b expected 1", stable); end
        tick(); // E6
        n_cmp++; if (sw_rise !== 9'h000) begin n_err++; $display("FAIL t2_rise_e6: got %h expected %h", sw_rise, 9'h000); end
    endtask

    task automatic test_glitch();
        sw_raw = 9'h101;
        tick(); // E0
        tick(); // E1
        sw_raw = 9'h100;
        repeat (2) tick(); // E3
        n_cmp++; if (stable !== 1'b0) begin n_err++; $display("FAIL t3_stable_e3: got %b expected 0", stable); end
        tick(); // E4: aborted
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL t3_stable_e4: got %b expected 1", stable); end
`ifdef SWCOND_GLITCH_CNT_EN
        n_cmp++; if (glitch_cnt !== 8'd1) begin n_err++; $display("FAIL t3_glitch_cnt: got %0d expected 1", glitch_cnt); end
`endif
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (sw_clean !== 9'h100 || sw_rise !== 9'h000) begin
                n_err++; $display("FAIL t3_no_change[%0d]: got clean=%h rise=%h expected clean=100 rise=000", k, sw_clean, sw_rise);
            end
            tick();
        end
    endtask

    task automatic test_fall_bit8();
        sw_raw = 9'h000;
        repeat (5) tick(); // E4
        n_cmp++; if (sw_clean !== 9'h100) begin n_err++; $display("FAIL t4_clean_e4: got %h expected %h", sw_clean, 9'h100); end
        tick(); // E5
        n_cmp++; if (sw_clean !== 9'h000) begin n_err++; $display("FAIL t4_clean_e5: got %h expected %h", sw_clean, 9'h000); end
        n_cmp++; if (sw_fall !== 9'h100) begin n_err++; $display("FAIL t4_fall_e5: got %h expected %h", sw_fall, 9'h100); end
        n_cmp++; if (sw_rise !== 9'h000) begin n_err++; $display("FAIL t4_rise_e5: got %h expected %h", sw_rise, 9'h000); end
        tick(); // E6
        n_cmp++; if (sw_fall !== 9'h000) begin n_err++; $display("FAIL t4_fall_e6: got %h expected %h", sw_fall, 9'h000); end
    endtask

    task automatic test_independent_bits();
        sw_raw = 9'h088;
        tick(); // E0
        sw_raw = 9'h080;
        tick(); // E1
        sw_raw = 9'h088;
        repeat (4) tick(); // E5
        n_cmp++; if (sw_clean !== 9'h080) begin n_err++; $display("FAIL t5_clean_e5: got %h expected %h", sw_clean, 9'h080); end
        n_cmp++; if (sw_rise !== 9'h080) begin n_err++; $display("FAIL t5_rise_e5: got %h expected %h", sw_rise, 9'h080); end
        tick(); // E6
        n_cmp++; if (sw_clean !== 9'h080) begin n_err++; $display("FAIL t5_clean_e6: got %h expected %h", sw_clean, 9'h080); end
        n_cmp++; if (stable !== 1'b0) begin n_err++; $display("FAIL t5_stable_e6: got %b expected 0", stable); end
        tick(); // E7
        n_cmp++; if (sw_clean !== 9'h088) begin n_err++; $display("FAIL t5_clean_e7: got %h expected %h", sw_clean, 9'h088); end
        n_cmp++; if (sw_rise !== 9'h008) begin n_err++; $display("FAIL t5_rise_e7: got %h expected %h", sw_rise, 9'h008); end
`ifdef SWCOND_GLITCH_CNT_EN
        n_cmp++; if (glitch_cnt !== 8'd2) begin n_err++; $display("FAIL t5_glitch_cnt: got %0d expected 2", glitch_cnt); end
`endif
    endtask

    task automatic test_reset_mid_count();
        sw_raw = 9'h0A8;
        repeat (4) tick(); // E3: cnt[5]=2
        n_cmp++; if (stable !== 1'b0) begin n_err++; $display("FAIL t6_stable_pre: got %b expected 0", stable); end
        reset = 1'b1;
        tick(); // E4 with reset
        reset = 1'b0;
        n_cmp++; if (sw_clean !== 9'h000) begin n_err++; $display("FAIL t6_clean_reset: got %h expected %h", sw_clean, 9'h000); end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL t6_stable_reset: got %b expected 1", stable); end
        n_cmp++; if (sw_rise !== 9'h000 || sw_fall !== 9'h000) begin
            n_err++; $display("FAIL t6_no_pulse: got rise=%h fall=%h expected 000/000", sw_rise, sw_fall);
        end
`ifdef SWCOND_GLITCH_CNT_EN
        n_cmp++; if (glitch_cnt !== 8'd0) begin n_err++; $display("FAIL t6_glitch_reset: got %0d expected 0", glitch_cnt); end
`endif
        repeat (5) tick(); // F4
        n_cmp++; if (sw_clean !== 9'h000) begin n_err++; $display("FAIL t6_clean_f4: got %h expected %h", sw_clean, 9'h000); end
        tick(); // F5
        n_cmp++; if (sw_clean !== 9'h0A8) begin n_err++; $display("FAIL t6_clean_f5: got %h expected %h", sw_clean, 9'h0A8); end
        n_cmp++; if (sw_rise !== 9'h0A8) begin n_err++; $display("FAIL t6_rise_f5: got %h expected %h", sw_rise, 9'h0A8); end
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = '0;
        test_reset();
        test_rise_bit8();
        test_glitch();
        test_fall_bit8();
        test_independent_bits();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
